dataint_ecc_secded_check_pipe: RTL and testbench

Pipelined SECDED checker/corrector that sits directly downstream of the SECDED encoder, typically at a memory or register-file read port. It accepts encoded codewords over a valid/ready interface, computes syndrome and overall parity, corrects single-bit errors and flags double-bit errors. It keeps saturating error counters and passes a sideband tag alongside each word.

---
 rtl/dataint_ecc_secded_check_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_dataint_ecc_secded_check_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dataint_ecc_secded_check_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dataint_ecc_secded_check_pipe
// Brief    : Two-stage SECDED check/correct pipeline with saturating error
//            counters; optional first-error log under DATAINT_ECC_ERR_LOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dataint_ecc_secded_check_pipe #(
  parameter  int WIDTH       = 32,
  parameter  int TAG_W       = 8,
  parameter  int CNT_W       = 16,
  localparam int PARITY_BITS = $clog2(WIDTH + $clog2(WIDTH) + 1),
  localparam int TOTAL_W     = WIDTH + PARITY_BITS + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [TOTAL_W-1:0]     s_codeword,
  input  logic [TAG_W-1:0]       s_tag,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic [TAG_W-1:0]       m_tag,
  output logic                   m_err_single,
  output logic                   m_err_double,
  input  logic                   cnt_clear,
  output logic [CNT_W-1:0]       cnt_single,
  output logic [CNT_W-1:0]       cnt_double
`ifdef DATAINT_ECC_ERR_LOG_EN
  ,
  output logic                   log_valid,
  output logic [PARITY_BITS-1:0] log_syndrome,
  output logic [TAG_W-1:0]       log_tag
`endif
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  // Codeword index of data bit k: k-th non-power-of-two Hamming position, minus one.
  function automatic int data_index(input int k);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 1; p < TOTAL_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) res = p - 1;
        cnt++;
      end
    end
    return res;
  endfunction

  logic                   w_adv1;
  logic                   w_adv2;
  logic                   w_accept;
  logic [PARITY_BITS-1:0] w_syn;
  logic                   w_par;
  logic [WIDTH-1:0]       w_raw_data;
  logic [WIDTH-1:0]       w_data;
  logic                   w_syn_nz;
  logic                   w_in_range;
  logic                   w_flip;
  logic                   w_single;
  logic                   w_double;

  logic                   r_v1;
  logic [WIDTH-1:0]       r_data1;
  logic [TAG_W-1:0]       r_tag1;
  logic [PARITY_BITS-1:0] r_syn1;
  logic                   r_par1;

  logic                   r_v2;
  logic [WIDTH-1:0]       r_data2;
  logic [TAG_W-1:0]       r_tag2;
  logic                   r_es2;
  logic                   r_ed2;

  logic [CNT_W-1:0]       r_cnt_s;
  logic [CNT_W-1:0]       r_cnt_d;

  assign w_adv2   = !r_v2 || m_ready;
  assign w_adv1   = !r_v1 || w_adv2;
  assign s_ready  = w_adv1;
  assign w_accept = r_v2 && m_ready;

  always_comb begin
    w_syn = '0;
    for (int i = 0; i < PARITY_BITS; i++) begin
      for (int j = 0; j < TOTAL_W - 1; j++) begin
        if ((((j + 1) >> i) & 1) != 0) w_syn[i] = w_syn[i] ^ s_codeword[j];
      end
    end
  end

  assign w_par = ^s_codeword;

  assign w_syn_nz   = |r_syn1;
  assign w_in_range = (int'(r_syn1) <= TOTAL_W - 1);
  assign w_flip     = w_syn_nz && r_par1 && w_in_range;
  assign w_single   = r_par1 && (!w_syn_nz || w_in_range);
  assign w_double   = w_syn_nz && (!r_par1 || !w_in_range);

  // Only data bits are carried past stage 1; a flip aimed at a parity position has no data effect.
  for (genvar k = 0; k < WIDTH; k++) begin : g_data_bit
    localparam int c_idx = data_index(k);
    assign w_raw_data[k] = s_codeword[c_idx];
    assign w_data[k]     = r_data1[k] ^ (w_flip && (r_syn1 == PARITY_BITS'(c_idx + 1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_data1 <= '0;
      r_tag1  <= '0;
      r_syn1  <= '0;
      r_par1  <= 1'b0;
      r_v2    <= 1'b0;
      r_data2 <= '0;
      r_tag2  <= '0;
      r_es2   <= 1'b0;
      r_ed2   <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_v1    <= s_valid;
        r_data1 <= w_raw_data;
        r_tag1  <= s_tag;
        r_syn1  <= w_syn;
        r_par1  <= w_par;
      end
      if (w_adv2) begin
        r_v2    <= r_v1;
        r_data2 <= w_data;
        r_tag2  <= r_tag1;
        r_es2   <= r_v1 && w_single;
        r_ed2   <= r_v1 && w_double;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_s <= '0;
      r_cnt_d <= '0;
    end else if (cnt_clear) begin
      r_cnt_s <= '0;
      r_cnt_d <= '0;
    end else if (w_accept) begin
      if (r_es2 && (r_cnt_s != c_cnt_max)) r_cnt_s <= r_cnt_s + CNT_W'(1);
      if (r_ed2 && (r_cnt_d != c_cnt_max)) r_cnt_d <= r_cnt_d + CNT_W'(1);
    end
  end

`ifdef DATAINT_ECC_ERR_LOG_EN
  logic [PARITY_BITS-1:0] r_syn2;
  logic                   r_log_valid;
  logic [PARITY_BITS-1:0] r_log_syn;
  logic [TAG_W-1:0]       r_log_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_syn2 <= '0;
    end else if (w_adv2) begin
      r_syn2 <= r_syn1;
    end
  end

  // Sticky until cleared: only the first erroneous word delivered is recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_log_valid <= 1'b0;
      r_log_syn   <= '0;
      r_log_tag   <= '0;
    end else if (cnt_clear) begin
      r_log_valid <= 1'b0;
      r_log_syn   <= '0;
      r_log_tag   <= '0;
    end else if (w_accept && (r_es2 || r_ed2) && !r_log_valid) begin
      r_log_valid <= 1'b1;
      r_log_syn   <= r_syn2;
      r_log_tag   <= r_tag2;
    end
  end

  assign log_valid    = r_log_valid;
  assign log_syndrome = r_log_syn;
  assign log_tag      = r_log_tag;
`endif

  assign m_valid      = r_v2;
  assign m_data       = r_data2;
  assign m_tag        = r_tag2;
  assign m_err_single = r_es2;
  assign m_err_double = r_ed2;
  assign cnt_single   = r_cnt_s;
  assign cnt_double   = r_cnt_d;

endmodule
`default_nettype wire

// File: tb/tb_dataint_ecc_secded_check_pipe.sv
`default_nettype none
// Randomized self-checking bench for dataint_ecc_secded_check_pipe with a positional
// Hamming reference model and an ordered scoreboard.
`timescale 1ns/1ps
module tb_dataint_ecc_secded_check_pipe;

  localparam int WIDTH = 32;
  localparam int TAG_W = 8;
  localparam int CNT_W = 4;
  localparam int PB    = $clog2(WIDTH + $clog2(WIDTH) + 1);
  localparam int TW    = WIDTH + PB + 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [TAG_W-1:0] t;
    logic             es;
    logic             ed;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [TW-1:0]    s_codeword;
  logic [TAG_W-1:0] s_tag;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [TAG_W-1:0] m_tag;
  logic             m_err_single;
  logic             m_err_double;
  logic             cnt_clear;
  logic [CNT_W-1:0] cnt_single;
  logic [CNT_W-1:0] cnt_double;
`ifdef DATAINT_ECC_ERR_LOG_EN
  logic             log_valid;
  logic [PB-1:0]    log_syndrome;
  logic [TAG_W-1:0] log_tag;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int exp_cs  = 0;
  int exp_cd  = 0;

  dataint_ecc_secded_check_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_codeword(s_codeword), .s_tag(s_tag),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_tag(m_tag),
    .m_err_single(m_err_single), .m_err_double(m_err_double),
    .cnt_clear(cnt_clear), .cnt_single(cnt_single), .cnt_double(cnt_double)
`ifdef DATAINT_ECC_ERR_LOG_EN
    , .log_valid(log_valid), .log_syndrome(log_syndrome), .log_tag(log_tag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Parity bit i equals bit i of the XOR of all Hamming positions holding a 1.
  function automatic logic [TW-1:0] encode(input logic [WIDTH-1:0] d);
    logic [TW-1:0] cw;
    int k;
    int s;
    cw = '0; k = 0; s = 0;
    for (int p = 1; p < TW; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[k];
        if (d[k]) s = s ^ p;
        k++;
      end
    end
    for (int i = 0; i < PB; i++) cw[(1 << i) - 1] = s[i];
    cw[TW-1] = ^cw[TW-2:0];
    return cw;
  endfunction

  function automatic logic [WIDTH-1:0] extract(input logic [TW-1:0] cw);
    logic [WIDTH-1:0] d;
    int k;
    d = '0; k = 0;
    for (int p = 1; p < TW; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = cw[p-1];
        k++;
      end
    end
    return d;
  endfunction

  function automatic int syn_of(input logic [TW-1:0] cw);
    int s;
    s = 0;
    for (int j = 0; j < TW - 1; j++) if (cw[j]) s = s ^ (j + 1);
    return s;
  endfunction

  function automatic exp_t predict(input logic [TW-1:0] cw, input logic [WIDTH-1:0] orig,
                                   input logic [TAG_W-1:0] tag);
    exp_t e;
    int s;
    s = syn_of(cw);
    e.t = tag; e.es = 1'b0; e.ed = 1'b0; e.d = extract(cw);
    if (s == 0 && !(^cw)) begin
      e.d = extract(cw);
    end else if ((^cw) && s <= TW - 1) begin
      e.es = 1'b1;
      e.d  = orig;
    end else begin
      e.ed = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [TW-1:0] corrupt(input logic [TW-1:0] cw, input int nerr);
    logic [TW-1:0] c;
    int a;
    int b;
    c = cw;
    a = $urandom_range(0, TW - 1);
    b = a;
    if (nerr >= 1) c[a] = ~c[a];
    if (nerr >= 2) begin
      while (b == a) b = $urandom_range(0, TW - 1);
      c[b] = ~c[b];
    end
    return c;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; cnt_clear = 1'b0;
    s_codeword = '0; s_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cs = 0; exp_cd = 0;
  endtask

  // Presents one word; returns two cycles later when it should sit at the output.
  task automatic send_one(input logic [TW-1:0] cw, input logic [TAG_W-1:0] tag);
    s_codeword = cw; s_tag = tag; s_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1 s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_valid); else n_pass++;
    n_total++; if (m_data !== '0 || m_tag !== '0) $display("FAIL reset_m_data got %h/%h want 0/0", m_data, m_tag); else n_pass++;
    n_total++; if ({m_err_single, m_err_double} !== 2'b00) $display("FAIL reset_flags got %b%b want 00", m_err_single, m_err_double); else n_pass++;
    n_total++; if (cnt_single !== '0 || cnt_double !== '0) $display("FAIL reset_counters got %0d/%0d want 0/0", cnt_single, cnt_double); else n_pass++;
    n_total++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got %b want 1", s_ready); else n_pass++;
`ifdef DATAINT_ECC_ERR_LOG_EN
    n_total++; if (log_valid !== 1'b0 || log_tag !== '0 || log_syndrome !== '0) $display("FAIL reset_log got %b/%h/%h want 0/0/0", log_valid, log_tag, log_syndrome); else n_pass++;
`endif
  endtask

  task automatic test_clean();
    send_one(encode(32'hDEADBEEF), 8'h5A);
    n_total++; if (m_valid !== 1'b1) $display("FAIL clean_latency m_valid got %b want 1", m_valid); else n_pass++;
    n_total++; if (m_data !== 32'hDEADBEEF) $display("FAIL clean_data got %h want deadbeef", m_data); else n_pass++;
    n_total++; if (m_tag !== 8'h5A) $display("FAIL clean_tag got %h want 5a", m_tag); else n_pass++;
    n_total++; if ({m_err_single, m_err_double} !== 2'b00) $display("FAIL clean_flags got %b%b want 00", m_err_single, m_err_double); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (cnt_single !== CNT_W'(exp_cs) || cnt_double !== CNT_W'(exp_cd)) $display("FAIL clean_counters got %0d/%0d want %0d/%0d", cnt_single, cnt_double, exp_cs, exp_cd); else n_pass++;
    n_total++; if (m_valid !== 1'b0) $display("FAIL clean_drain m_valid got %b want 0", m_valid); else n_pass++;
  endtask

  task automatic test_single();
    logic [TW-1:0] cw;
    cw = encode(32'h12345678); cw[6] = ~cw[6];
    send_one(cw, 8'h11);
    n_total++; if (m_data !== 32'h12345678) $display("FAIL single_data got %h want 12345678", m_data); else n_pass++;
    n_total++; if ({m_err_single, m_err_double} !== 2'b10) $display("FAIL single_flags got %b%b want 10", m_err_single, m_err_double); else n_pass++;
    @(posedge clk); #1; exp_cs++;
    n_total++; if (cnt_single !== CNT_W'(exp_cs)) $display("FAIL single_count got %0d want %0d", cnt_single, exp_cs); else n_pass++;
    cw = encode(32'h12345678); cw[TW-1] = ~cw[TW-1];
    send_one(cw, 8'h12);
    n_total++; if (m_data !== 32'h12345678) $display("FAIL overall_bit_data got %h want 12345678", m_data); else n_pass++;
    n_total++; if ({m_err_single, m_err_double} !== 2'b10) $display("FAIL overall_bit_flags got %b%b want 10", m_err_single, m_err_double); else n_pass++;
    @(posedge clk); #1; exp_cs++;
    n_total++; if (cnt_single !== CNT_W'(exp_cs)) $display("FAIL overall_bit_count got %0d want %0d", cnt_single, exp_cs); else n_pass++;
  endtask

  task automatic test_double();
    logic [TW-1:0] cw;
    exp_t e;
    cw = encode(32'h12345678); cw[2] = ~cw[2]; cw[9] = ~cw[9];
    e = predict(cw, 32'h12345678, 8'h21);
    send_one(cw, 8'h21);
    n_total++; if (m_data !== e.d) $display("FAIL double_data got %h want %h", m_data, e.d); else n_pass++;
    n_total++; if ({m_err_single, m_err_double} !== 2'b01) $display("FAIL double_flags got %b%b want 01", m_err_single, m_err_double); else n_pass++;
    @(posedge clk); #1; exp_cd++;
    n_total++; if (cnt_double !== CNT_W'(exp_cd)) $display("FAIL double_count got %0d want %0d", cnt_double, exp_cd); else n_pass++;
    // Positions 32,16,8 give a syndrome of 56, beyond the codeword, with odd parity.
    cw = encode(32'hCAFEF00D); cw[31] = ~cw[31]; cw[15] = ~cw[15]; cw[7] = ~cw[7];
    send_one(cw, 8'h22);
    n_total++; if (m_data !== 32'hCAFEF00D) $display("FAIL oob_syndrome_data got %h want cafef00d", m_data); else n_pass++;
    n_total++; if ({m_err_single, m_err_double} !== 2'b01) $display("FAIL oob_syndrome_flags got %b%b want 01", m_err_single, m_err_double); else n_pass++;
    @(posedge clk); #1; exp_cd++;
    n_total++; if (cnt_double !== CNT_W'(exp_cd)) $display("FAIL oob_syndrome_count got %0d want %0d", cnt_double, exp_cd); else n_pass++;
  endtask

  // mode 0: m_ready cycles 1,0,0,1; mode 1: random m_ready. err_mode -1: random 0..2 errors.
  task automatic test_stream(input string name, input int n, input int mode, input int err_mode);
    logic [TW-1:0]    in_cw[$];
    logic [TAG_W-1:0] in_tag[$];
    exp_t             sb[$];
    exp_t             e;
    logic [WIDTH+TAG_W+1:0] held;
    logic [WIDTH-1:0] d;
    logic [TW-1:0]    cw;
    logic             stalled;
    logic             exp_rdy;
    int sent;
    int recv;
    int cyc;
    for (int i = 0; i < n; i++) begin
      d  = $urandom;
      cw = corrupt(encode(d), (err_mode < 0) ? $urandom_range(0, 2) : err_mode);
      in_cw.push_back(cw);
      in_tag.push_back(TAG_W'(i + 8'h40));
      sb.push_back(predict(cw, d, TAG_W'(i + 8'h40)));
    end
    sent = 0; recv = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (recv < n && cyc < 2000) begin
      m_ready = (mode == 0) ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'($urandom_range(0, 1));
      s_valid = (sent < n);
      if (sent < n) begin
        s_codeword = in_cw[sent];
        s_tag      = in_tag[sent];
      end
      #1;
      n_total++; if (cnt_single !== CNT_W'(exp_cs) || cnt_double !== CNT_W'(exp_cd)) $display("FAIL %s_counters cyc %0d got %0d/%0d want %0d/%0d", name, cyc, cnt_single, cnt_double, exp_cs, exp_cd); else n_pass++;
      exp_rdy = !((sent - recv) == 2 && !m_ready);
      n_total++; if (s_ready !== exp_rdy) $display("FAIL %s_s_ready cyc %0d got %b want %b", name, cyc, s_ready, exp_rdy); else n_pass++;
      if (stalled) begin
        n_total++; if (m_valid !== 1'b1 || {m_data, m_tag, m_err_single, m_err_double} !== held) $display("FAIL %s_stall_hold cyc %0d got %b/%h want 1/%h", name, cyc, m_valid, {m_data, m_tag, m_err_single, m_err_double}, held); else n_pass++;
      end
      if (m_valid && m_ready) begin
        e = sb.pop_front();
        n_total++; if ({m_data, m_tag, m_err_single, m_err_double} !== e) $display("FAIL %s_word %0d got %h/%h/%b%b want %h/%h/%b%b", name, recv, m_data, m_tag, m_err_single, m_err_double, e.d, e.t, e.es, e.ed); else n_pass++;
        if (e.es && exp_cs < CMAX) exp_cs++;
        if (e.ed && exp_cd < CMAX) exp_cd++;
        recv++;
      end
      stalled = m_valid && !m_ready;
      held    = {m_data, m_tag, m_err_single, m_err_double};
      if (s_valid && s_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
    n_total++; if (recv != n) $display("FAIL %s_timeout received %0d want %0d", name, recv, n); else n_pass++;
    n_total++; if (m_valid !== 1'b0) $display("FAIL %s_extra_word m_valid got %b want 0", name, m_valid); else n_pass++;
  endtask

  task automatic test_saturate();
    test_stream("saturate", 20, 1, 1);
    n_total++; if (cnt_single !== CNT_W'(CMAX)) $display("FAIL saturate_value got %0d want %0d", cnt_single, CMAX); else n_pass++;
  endtask

  task automatic test_clear();
    logic [TW-1:0] cw;
    cw = encode(32'h0F0F0F0F); cw[20] = ~cw[20];
    send_one(cw, 8'h77);
    n_total++; if (m_valid !== 1'b1 || m_err_single !== 1'b1) $display("FAIL clear_word got %b/%b want 1/1", m_valid, m_err_single); else n_pass++;
    cnt_clear = 1'b1;
    @(posedge clk); #1 cnt_clear = 1'b0;
    exp_cs = 0; exp_cd = 0;
    n_total++; if (cnt_single !== '0 || cnt_double !== '0) $display("FAIL clear_priority got %0d/%0d want 0/0", cnt_single, cnt_double); else n_pass++;
`ifdef DATAINT_ECC_ERR_LOG_EN
    n_total++; if (log_valid !== 1'b0) $display("FAIL clear_log got %b want 0", log_valid); else n_pass++;
`endif
  endtask

`ifdef DATAINT_ECC_ERR_LOG_EN
  task automatic test_log();
    logic [TW-1:0] cw;
    send_one(encode(32'h00000001), 8'h90);
    @(posedge clk); #1;
    n_total++; if (log_valid !== 1'b0) $display("FAIL log_clean got %b want 0", log_valid); else n_pass++;
    cw = encode(32'h55AA55AA); cw[10] = ~cw[10];
    send_one(cw, 8'hA1);
    @(posedge clk); #1; exp_cs++;
    n_total++; if (log_valid !== 1'b1 || log_tag !== 8'hA1 || log_syndrome !== PB'(11)) $display("FAIL log_first got %b/%h/%0d want 1/a1/11", log_valid, log_tag, log_syndrome); else n_pass++;
    cw = encode(32'h55AA55AA); cw[3] = ~cw[3]; cw[12] = ~cw[12];
    send_one(cw, 8'hB2);
    @(posedge clk); #1; exp_cd++;
    n_total++; if (log_valid !== 1'b1 || log_tag !== 8'hA1 || log_syndrome !== PB'(11)) $display("FAIL log_sticky got %b/%h/%0d want 1/a1/11", log_valid, log_tag, log_syndrome); else n_pass++;
  endtask
`endif

  task automatic test_reset_midstream();
    logic [TW-1:0] cw;
    bit seen;
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cw = encode(32'hA5A50000 + i); cw[5] = ~cw[5];
      s_codeword = cw; s_tag = TAG_W'(8'hE0 + i); s_valid = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    n_total++; if (m_valid !== 1'b1 || s_ready !== 1'b0) $display("FAIL midreset_full got %b/%b want 1/0", m_valid, s_ready); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (m_valid !== 1'b0 || m_data !== '0 || m_tag !== '0) $display("FAIL midreset_outputs got %b/%h/%h want 0/0/0", m_valid, m_data, m_tag); else n_pass++;
    n_total++; if (cnt_single !== '0 || cnt_double !== '0) $display("FAIL midreset_counters got %0d/%0d want 0/0", cnt_single, cnt_double); else n_pass++;
`ifdef DATAINT_ECC_ERR_LOG_EN
    n_total++; if (log_valid !== 1'b0) $display("FAIL midreset_log got %b want 0", log_valid); else n_pass++;
`endif
    @(posedge clk); #1 rst_n = 1'b1; m_ready = 1'b1;
    exp_cs = 0; exp_cd = 0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (m_valid) seen = 1'b1;
    end
    n_total++; if (seen) $display("FAIL midreset_replay got m_valid=1 want 0"); else n_pass++;
    n_total++; if (s_ready !== 1'b1) $display("FAIL midreset_s_ready got %b want 1", s_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_saturate();
    test_clear();
`ifdef DATAINT_ECC_ERR_LOG_EN
    test_log();
`endif
    test_stream("backpressure", 8, 0, -1);
    test_stream("random", 40, 1, -1);
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
